// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the register file slice.
// Address width is derived from the register count.
package rf_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int RF_DEPTH_DEF = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per register.
// Set by accepted issue, cleared by writeback, wiped by flush.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int  DEPTH = RF_DEPTH_DEF,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_idx,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_idx,
  input  logic             flush,
  output logic [DEPTH-1:0] busy_vec
);

  logic [DEPTH-1:0] nxt;

  // Set is applied after clear: a new producer owns the register.
  always_comb begin
    nxt = busy_vec;
    if (clr_en) nxt[clr_idx] = 1'b0;
    if (set_en) nxt[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_vec <= '0;
    end else if (flush) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= nxt;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with write->read bypass, optional zero register
// and busy-bit hazard check for decode issue.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int  XLEN     = XLEN_DEF,
  parameter int  DEPTH    = RF_DEPTH_DEF,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 1,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [XLEN-1:0]  rd_data1,
  output logic [XLEN-1:0]  rd_data2,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [XLEN-1:0]  wr_data,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic             iss_ready,
  input  logic             flush,
  output logic [DEPTH-1:0] busy_vec
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [AW-1:0]    ra  [2];
  logic [XLEN-1:0]  rdv [2];
  logic [DEPTH-1:0] eb;
  logic             wr_ok;
  logic             byp;
  logic             set_en;

  assign wr_ok = we && !(ZR && (wr_addr == '0));
  assign byp   = BP && wr_ok;
  assign ra[0] = rd_addr1;
  assign ra[1] = rd_addr2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdv[p] = mem[ra[p]];
      if (byp && (wr_addr == ra[p])) rdv[p] = wr_data;
      if (!rst || (ZR && (ra[p] == '0))) rdv[p] = '0;
    end
  end

  assign rd_data1 = rdv[0];
  assign rd_data2 = rdv[1];

  // A register being written back this cycle no longer blocks.
  always_comb begin
    eb = busy_vec;
    if (BP && we) eb[wr_addr] = 1'b0;
    if (ZR) eb[0] = 1'b0;
  end

  assign iss_ready = rst & ~flush
                   & ~eb[rd_addr1]
                   & ~eb[rd_addr2]
                   & ~eb[iss_rd];

  assign set_en = iss_valid & iss_ready
                & !(ZR && (iss_rd == '0));

  rf_scoreboard #(
    .DEPTH (DEPTH)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .set_idx  (iss_rd),
    .clr_en   (we),
    .clr_idx  (wr_addr),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

endmodule
